// File: rtl/mul_seq_unit.sv
// Sequential 32x32 shift-add multiplier covering the MUL/MULH/MULHSU/MULHU word selects.
// Works on operand magnitudes over 32 fixed iterations, then applies the product sign in one fix-up cycle.

module mul_seq_unit_cla32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g    = x & y;
    assign p    = x ^ y;
    assign c[0] = cin;

    // 4-bit lookahead groups; the group carry-out ripples into the next group.
    for (genvar i = 0; i < 8; i++) begin : g_blk
        localparam int B = 4 * i;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
endmodule

// state | meaning
// IDLE  | waiting for start
// CALC  | 32 shift-add iterations on the magnitudes
// FIX   | apply product sign, select result word
// DONE  | one-cycle done pulse; start here chains straight into CALC
module mul_seq_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] mag_a;
    logic        neg;
    logic [63:0] acc;
    logic [4:0]  count;

    logic        a_signed;
    logic        b_signed;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic        sign_in;
    logic [31:0] addend;
    logic [31:0] sum;
    logic        cout;
    logic [63:0] acc_fix;

    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU);
    assign b_signed = (op == OP_MULH);
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign a_mag_in = (a_signed && a[31]) ? (~a + 32'd1) : a;
    assign b_mag_in = (b_signed && b[31]) ? (~b + 32'd1) : b;
    assign sign_in  = (a_signed & a[31]) ^ (b_signed & b[31]);

    assign addend  = acc[0] ? mag_a : 32'd0;
    assign acc_fix = neg ? (~acc + 64'd1) : acc;

    mul_seq_unit_cla32 u_add (
        .x    (acc[63:32]),
        .y    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
            acc    <= 64'd0;
            count  <= 5'd0;
            op_q   <= OP_MUL;
            mag_a  <= 32'd0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        mag_a <= a_mag_in;
                        neg   <= sign_in;
                        acc   <= {32'd0, b_mag_in};
                        count <= 5'd0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc   <= {cout, sum, acc[31:1]};
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= (op_q == OP_MUL) ? acc_fix[31:0] : acc_fix[63:32];
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
